// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard controller.
// Holds the MDU state encoding and the r0-aware register compare.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hardwired to zero, so it can never carry a pending result
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_timer.sv
// Multiply/divide busy window: IDLE/BUSY FSM with a LAT-cycle countdown.
// Busy starts the edge after mdu_start_e; starts while busy are ignored.
module mdu_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_start_e,
  input  logic mdu_div_e,
  output logic mdu_busy,
  output logic mdu_done
);

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Loaded with LAT-1 and run down to zero, giving exactly LAT busy cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (mdu_start_e) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = mdu_div_e ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        end
      end
      MDU_BUSY: begin
        mdu_busy = 1'b1;
        if (cnt == '0) begin
          mdu_done  = 1'b1;
          state_nxt = MDU_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline; stalls and flushes are combinational.
// Precedence per cycle: hazard stall > taken transfer > fetch wait; lost cycles counted.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int PC_BITS  = 32,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        uses_rt_d,
  input  logic        branch_d,
  input  logic        take_d,
  input  logic        mdu_op_d,
  input  logic        hilo_rd_d,
  input  logic [4:0]  write_reg_e,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic [4:0]  write_reg_m,
  input  logic        mem_to_reg_m,
  input  logic        mdu_start_e,
  input  logic        mdu_div_e,
  input  logic        imem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  if (PC_BITS < 1 || MULT_LAT < 2 || DIV_LAT < MULT_LAT ||
      (DIV_LAT - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("pipeline_hazard_ctrl: inconsistent parameters");
  end

  logic lu, bh, mh, hz;
  logic e_hits_src, m_hits_src;

  mdu_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_mdu_timer (
    .clk         (clk),
    .rst         (rst),
    .mdu_start_e (mdu_start_e),
    .mdu_div_e   (mdu_div_e),
    .mdu_busy    (mdu_busy),
    .mdu_done    (mdu_done)
  );

  // Branches compare in D, so both operands must be final, not just forwardable
  assign e_hits_src = reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d);
  assign m_hits_src = reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d);

  assign lu = mem_to_reg_e &&
              (reg_match(write_reg_e, rs_d) || (uses_rt_d && reg_match(write_reg_e, rt_d)));
  assign bh = branch_d && ((reg_write_e && e_hits_src) || (mem_to_reg_m && m_hits_src));
  assign mh = mdu_busy && (mdu_op_d || hilo_rd_d);
  assign hz = lu || bh || mh;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (take_d) begin
      // PC must load the target, so a pending fetch wait cannot hold it
      flush_d = 1'b1;
    end else if (!imem_ready) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_d && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_d, rt_d, write_reg_e, write_reg_m;
  logic        uses_rt_d, branch_d, take_d, mdu_op_d, hilo_rd_d;
  logic        reg_write_e, mem_to_reg_e, mem_to_reg_m;
  logic        mdu_start_e, mdu_div_e, imem_ready;
  logic        stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_done;
  logic [31:0] stall_cycles;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference state: remaining busy cycles of the MDU, and the lost-cycle tally
  int          m_busy_left;
  logic [31:0] m_stalls;

  pipeline_hazard_ctrl #(
    .PC_BITS  (32),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .uses_rt_d    (uses_rt_d),
    .branch_d     (branch_d),
    .take_d       (take_d),
    .mdu_op_d     (mdu_op_d),
    .hilo_rd_d    (hilo_rd_d),
    .write_reg_e  (write_reg_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .write_reg_m  (write_reg_m),
    .mem_to_reg_m (mem_to_reg_m),
    .mdu_start_e  (mdu_start_e),
    .mdu_div_e    (mdu_div_e),
    .imem_ready   (imem_ready),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit reads(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // Expected {stall_f, stall_d, flush_d, flush_e} from the current inputs and model state
  function automatic logic [3:0] expect_ctl();
    bit lu, bh, mh;
    if (rst) return 4'b0011;
    lu = mem_to_reg_e && (reads(write_reg_e, rs_d) || (uses_rt_d && reads(write_reg_e, rt_d)));
    bh = branch_d &&
         ((reg_write_e  && (reads(write_reg_e, rs_d) || reads(write_reg_e, rt_d))) ||
          (mem_to_reg_m && (reads(write_reg_m, rs_d) || reads(write_reg_m, rt_d))));
    mh = (m_busy_left > 0) && (mdu_op_d || hilo_rd_d);
    if (lu || bh || mh) return 4'b1101;
    if (take_d)         return 4'b0010;
    if (!imem_ready)    return 4'b1010;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [3:0] e;
    e = expect_ctl();
    chk({tag, ".stall_f"},  32'(stall_f),  32'(e[3]));
    chk({tag, ".stall_d"},  32'(stall_d),  32'(e[2]));
    chk({tag, ".flush_d"},  32'(flush_d),  32'(e[1]));
    chk({tag, ".flush_e"},  32'(flush_e),  32'(e[0]));
    chk({tag, ".mdu_busy"}, 32'(mdu_busy), (!rst && m_busy_left > 0) ? 32'd1 : 32'd0);
    chk({tag, ".mdu_done"}, 32'(mdu_done), (!rst && m_busy_left == 1) ? 32'd1 : 32'd0);
    chk({tag, ".stall_cycles"}, stall_cycles, m_stalls);
  endtask

  // Check the settled outputs, advance one clock, update the model, return at negedge
  task automatic cycle(input string tag);
    logic [3:0] e;
    chk_all(tag);
    e = expect_ctl();
    @(posedge clk);
    if (!rst) begin
      if (m_busy_left > 0)  m_busy_left--;
      else if (mdu_start_e) m_busy_left = mdu_div_e ? DIV_LAT : MULT_LAT;
      if (e[2] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; write_reg_e = '0; write_reg_m = '0;
    uses_rt_d = 0; branch_d = 0; take_d = 0; mdu_op_d = 0; hilo_rd_d = 0;
    reg_write_e = 0; mem_to_reg_e = 0; mem_to_reg_m = 0;
    mdu_start_e = 0; mdu_div_e = 0; imem_ready = 1;
  endtask

  initial begin
    int busy_n, done_n, hold_n;

    rst = 1'b1;
    clear_inputs();
    m_busy_left = 0;
    m_stalls    = '0;
    #2;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load-use: lw r8 in E, add reading r8 in D
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5'd8; rs_d = 5'd8; rt_d = 5'd3; uses_rt_d = 1;
    #1;
    chk("lu.stall_d", 32'(stall_d), 32'd1);
    chk("lu.flush_e", 32'(flush_e), 32'd1);
    cycle("lu");
    clear_inputs();
    mem_to_reg_m = 1; write_reg_m = 5'd8; rs_d = 5'd8;
    #1;
    chk("lu_after.stall_d", 32'(stall_d), 32'd0);
    chk("lu_after.stall_cycles", stall_cycles, 32'd1);
    cycle("lu_after");

    // Branch on r9 just produced by an ALU op in E; take_d ignored while stalled
    clear_inputs();
    reg_write_e = 1; write_reg_e = 5'd9; branch_d = 1; rs_d = 5'd9; rt_d = 5'd4; take_d = 1;
    #1;
    chk("bh.stall_d", 32'(stall_d), 32'd1);
    chk("bh.flush_d", 32'(flush_d), 32'd0);
    cycle("bh");
    clear_inputs();
    branch_d = 1; rs_d = 5'd9; rt_d = 5'd4; take_d = 1;
    #1;
    chk("bh_take.flush_d", 32'(flush_d), 32'd1);
    chk("bh_take.stall_d", 32'(stall_d), 32'd0);
    cycle("bh_take");

    // Load-use, taken transfer and fetch wait together: the stall wins
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5'd5; rs_d = 5'd5; take_d = 1; imem_ready = 0;
    #1;
    chk("simul.stall_d", 32'(stall_d), 32'd1);
    chk("simul.flush_d", 32'(flush_d), 32'd0);
    chk("simul.flush_e", 32'(flush_e), 32'd1);
    cycle("simul");

    // Fetch wait alone bubbles D
    clear_inputs();
    imem_ready = 0;
    #1;
    chk("fwait.stall_f", 32'(stall_f), 32'd1);
    chk("fwait.flush_d", 32'(flush_d), 32'd1);
    cycle("fwait");

    // r0 destination is never a hazard
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5'd0; uses_rt_d = 1; branch_d = 1;
    #1;
    chk("r0.stall_d", 32'(stall_d), 32'd0);
    chk("r0.stall_cycles", stall_cycles, 32'd3);
    cycle("r0");

    // Divide at cycle t; mfhi enters D at t+5 and waits for the window to close
    clear_inputs();
    mdu_start_e = 1; mdu_div_e = 1;
    #1;
    chk("div.start_busy", 32'(mdu_busy), 32'd0);
    cycle("div.start");
    busy_n = 0; done_n = 0; hold_n = 0;
    for (int k = 1; k <= DIV_LAT + 1; k++) begin
      clear_inputs();
      if (k >= 5) hilo_rd_d = 1;
      #1;
      busy_n += int'(mdu_busy);
      done_n += int'(mdu_done);
      hold_n += int'(stall_d);
      if (k == DIV_LAT)     chk("div.done_last", 32'(mdu_done), 32'd1);
      if (k == DIV_LAT + 1) chk("div.mfhi_issues", 32'(stall_d), 32'd0);
      cycle("div");
    end
    chk("div.busy_cycles", 32'(busy_n), 32'(DIV_LAT));
    chk("div.done_pulses", 32'(done_n), 32'd1);
    chk("div.mfhi_stall_cycles", 32'(hold_n), 32'(DIV_LAT - 4));

    // Multiply interrupted by asynchronous reset
    clear_inputs();
    mdu_start_e = 1;
    cycle("mul.start");
    clear_inputs();
    cycle("mul.busy");
    #2;
    rst = 1'b1;
    #1;
    m_busy_left = 0;
    m_stalls    = '0;
    chk("rst_mid.mdu_busy", 32'(mdu_busy), 32'd0);
    chk("rst_mid.stall_cycles", stall_cycles, 32'd0);
    chk("rst_mid.flush_d", 32'(flush_d), 32'd1);
    chk("rst_mid.flush_e", 32'(flush_e), 32'd1);
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic over a small register set to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      rs_d         = 5'($urandom_range(0, 3));
      rt_d         = 5'($urandom_range(0, 3));
      write_reg_e  = 5'($urandom_range(0, 3));
      write_reg_m  = 5'($urandom_range(0, 3));
      uses_rt_d    = 1'($urandom_range(0, 1));
      branch_d     = ($urandom_range(0, 3) == 0);
      take_d       = ($urandom_range(0, 3) == 0);
      mdu_op_d     = ($urandom_range(0, 7) == 0);
      hilo_rd_d    = ($urandom_range(0, 5) == 0);
      reg_write_e  = 1'($urandom_range(0, 1));
      mem_to_reg_e = ($urandom_range(0, 2) == 0);
      mem_to_reg_m = ($urandom_range(0, 2) == 0);
      mdu_start_e  = ($urandom_range(0, 15) == 0);
      mdu_div_e    = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 4) != 0);
      #1;
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
